// File: rtl/fetch_queue.sv
// Fetch queue: issues instruction reads at the current PC, buffers in-order
// responses as (pc, instr) entries and hands them to decode.
// Ports:
//   clk, arst                 clock, async active-high reset
//   pc_in / pc_en_out         current PC in, advance strobe out
//   flush_in                  redirect, drops queued and in-flight fetches
//   imem_req_*                read request (valid/ready, addr)
//   imem_rsp_*                read response (valid, data), in request order
//   instr_* / instr_ready_in  head entry to decode (valid/ready)
module fetch_queue #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_en_out,
    input  logic               flush_in,
    output logic               imem_req_valid_out,
    output logic [ADDR_W-1:0]  imem_req_addr_out,
    input  logic               imem_req_ready_in,
    input  logic               imem_rsp_valid_in,
    input  logic [INSTR_W-1:0] imem_rsp_data_in,
    output logic               instr_valid_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc_out,
    input  logic               instr_ready_in
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [ADDR_W-1:0]  pc_d    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [INSTR_W-1:0] instr_d [DEPTH];
    logic [DEPTH-1:0]   filled_q, filled_d;
    logic [PW-1:0]      alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]      fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]      read_ptr_q, read_ptr_d;
    logic [CW-1:0]      alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      drop_cnt_q, drop_cnt_d;

    logic [CW:0] occ;
    logic        req_valid;
    logic        req_hs;
    logic        rsp_fire;
    logic        head_valid;
    logic        deq;

    // Outputs are forced low while reset is held, even before the first edge.
    always_comb begin
        occ        = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
        req_valid  = !arst && !flush_in && (occ < (CW+1)'(DEPTH));
        req_hs     = req_valid && imem_req_ready_in;
        rsp_fire   = imem_rsp_valid_in && (inflight_q != '0);
        head_valid = !arst && !flush_in && filled_q[read_ptr_q];
        deq        = head_valid && instr_ready_in;
    end

    assign pc_en_out          = req_hs;
    assign imem_req_valid_out = req_valid;
    assign imem_req_addr_out  = pc_in;
    assign instr_valid_out    = head_valid;
    assign instr_out          = instr_q[read_ptr_q];
    assign instr_pc_out       = pc_q[read_ptr_q];

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        read_ptr_d  = read_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        inflight_d  = inflight_q + CW'(req_hs) - CW'(rsp_fire);
        if (flush_in) begin
            // Everything still outstanding after this cycle's response
            // belongs to the old path and must be discarded on arrival.
            filled_d    = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            read_ptr_d  = '0;
            alloc_cnt_d = '0;
            drop_cnt_d  = inflight_d;
        end else begin
            if (req_hs) begin
                pc_d[alloc_ptr_q]     = pc_in;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + PW'(1);
            end
            if (rsp_fire) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    instr_d[fill_ptr_q]  = imem_rsp_data_in;
                    filled_d[fill_ptr_q] = 1'b1;
                    fill_ptr_d           = fill_ptr_q + PW'(1);
                end
            end
            if (deq) begin
                filled_d[read_ptr_q] = 1'b0;
                read_ptr_d           = read_ptr_q + PW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(req_hs) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc_q        <= '{default: '0};
            instr_q     <= '{default: '0};
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            read_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            inflight_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            read_ptr_q  <= read_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            inflight_q  <= inflight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // A response with nothing outstanding means the memory broke ordering.
    rsp_without_req : assert property (
        @(posedge clk) disable iff (arst)
        !(imem_rsp_valid_in && inflight_q == '0)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: scoreboard of (pc, instr) pushed at each
// request handshake, popped and compared at each decode handshake.
module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [AW-1:0] pc_in = '0;
    logic          pc_en_out;
    logic          flush_in = 1'b0;
    logic          imem_req_valid_out;
    logic [AW-1:0] imem_req_addr_out;
    logic          imem_req_ready_in = 1'b0;
    logic          imem_rsp_valid_in = 1'b0;
    logic [IW-1:0] imem_rsp_data_in = '0;
    logic          instr_valid_out;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc_out;
    logic          instr_ready_in = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W (AW),
        .INSTR_W(IW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .arst              (arst),
        .pc_in             (pc_in),
        .pc_en_out         (pc_en_out),
        .flush_in          (flush_in),
        .imem_req_valid_out(imem_req_valid_out),
        .imem_req_addr_out (imem_req_addr_out),
        .imem_req_ready_in (imem_req_ready_in),
        .imem_rsp_valid_in (imem_rsp_valid_in),
        .imem_rsp_data_in  (imem_rsp_data_in),
        .instr_valid_out   (instr_valid_out),
        .instr_out         (instr_out),
        .instr_pc_out      (instr_pc_out),
        .instr_ready_in    (instr_ready_in)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] mem_q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_hs = 0;
    int            n_deq = 0;
    bit            mem_en = 1'b1;
    bit            adv;
    bit            rsp_seen;
    bit            watch_flush = 1'b0;
    logic [AW-1:0] hs_addr;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mem_data(logic [AW-1:0] a);
        return a ^ 32'h5EED_0000 ^ {a[15:0], 16'h0};
    endfunction

    task automatic drive_rsp();
        imem_rsp_valid_in = mem_en && mem_q.size() != 0;
        imem_rsp_data_in  = (mem_q.size() != 0) ? mem_data(mem_q[0]) : '0;
    endtask

    task automatic monitor();
        exp_t e;
        adv      = 1'b0;
        rsp_seen = 1'b0;
        if (arst) return;
        rsp_seen = imem_rsp_valid_in;
        check("pc_en_hs", pc_en_out, imem_req_valid_out && imem_req_ready_in);
        if (imem_req_valid_out) check("req_addr", imem_req_addr_out, pc_in);
        if (flush_in) begin
            check("flush_quiet", {imem_req_valid_out, instr_valid_out}, 2'b00);
            sb.delete();
            return;
        end
        if (instr_valid_out && instr_ready_in) begin
            n_deq++;
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("instr_pc", instr_pc_out, e.pc);
                check("instr", instr_out, e.instr);
            end
            if (watch_flush) begin
                check("flush_first_pc", instr_pc_out, 32'h100);
                watch_flush = 1'b0;
            end
        end
        if (pc_en_out) begin
            adv     = 1'b1;
            hs_addr = pc_in;
            n_hs++;
            sb.push_back('{pc: pc_in, instr: mem_data(pc_in)});
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rsp_seen) mem_q.delete(0);
        if (adv) begin
            mem_q.push_back(hs_addr);
            pc_in = pc_in + 32'd4;
        end
        drive_rsp();
    endtask

    task automatic drain();
        int t = 0;
        imem_req_ready_in = 1'b0;
        instr_ready_in    = 1'b1;
        mem_en            = 1'b1;
        drive_rsp();
        while ((sb.size() != 0 || mem_q.size() != 0) && t < 50) begin
            step();
            t++;
        end
        check("drain_in_time", t < 50, 1);
        step();
        step();
        check("drained_sb", sb.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", imem_req_valid_out, 0);
        check("rst_pc_en", pc_en_out, 0);
        check("rst_instr_valid", instr_valid_out, 0);
        check("rst_instr", instr_out, 0);
        check("rst_instr_pc", instr_pc_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int d0;
        int t;

        // Reset held, memory ready: nothing may be issued.
        imem_req_ready_in = 1'b1;
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Streaming: one instruction per cycle once the pipe is full.
        instr_ready_in = 1'b1;
        repeat (4) step();
        d0 = n_deq;
        repeat (10) step();
        check("stream_rate", n_deq - d0, 10);
        drain();

        // Backpressure: exactly DEPTH requests, then one per dequeue.
        instr_ready_in    = 1'b0;
        imem_req_ready_in = 1'b1;
        h0 = n_hs;
        repeat (10) step();
        check("bp_hs", n_hs - h0, DEPTH);
        check("bp_stall", pc_en_out, 0);
        check("bp_head", instr_valid_out, 1);
        instr_ready_in = 1'b1;
        h0 = n_hs;
        d0 = n_deq;
        step();
        instr_ready_in = 1'b0;
        check("bp_deq", n_deq - d0, 1);
        check("bp_full_no_req", n_hs - h0, 0);
        step();
        check("bp_reopen", n_hs - h0, 1);
        repeat (4) step();
        check("bp_one_req", n_hs - h0, 1);
        drain();

        // Memory stall: address held at 0x10 until accepted.
        pc_in             = 32'h10;
        imem_req_ready_in = 1'b0;
        h0 = n_hs;
        repeat (5) begin
            check("stall_valid", imem_req_valid_out, 1);
            check("stall_addr", imem_req_addr_out, 32'h10);
            step();
        end
        check("stall_no_hs", n_hs - h0, 0);
        imem_req_ready_in = 1'b1;
        step();
        check("stall_resume", n_hs - h0, 1);
        drain();

        // Flush with two fetches in flight, redirect to 0x100.
        imem_req_ready_in = 1'b1;
        instr_ready_in    = 1'b1;
        mem_en            = 1'b0;
        drive_rsp();
        step();
        step();
        check("fl_outstanding", mem_q.size(), 2);
        mem_en      = 1'b1;
        drive_rsp();
        flush_in    = 1'b1;
        pc_in       = 32'h100;
        watch_flush = 1'b1;
        step();
        flush_in = 1'b0;
        d0 = n_deq;
        t  = 0;
        while (n_deq == d0 && t < 20) begin
            step();
            t++;
        end
        check("fl_emitted", n_deq - d0, 1);
        drain();

        // Async reset with three entries queued.
        imem_req_ready_in = 1'b1;
        instr_ready_in    = 1'b0;
        h0 = n_hs;
        t  = 0;
        while (n_hs - h0 < 3 && t < 20) begin
            step();
            t++;
        end
        imem_req_ready_in = 1'b0;
        repeat (3) step();
        check("rst_queued", instr_valid_out, 1);
        imem_req_ready_in = 1'b1;
        #2;
        arst = 1'b1;
        #1;
        check_reset_outputs();
        sb.delete();
        mem_q.delete();
        drive_rsp();
        step();
        step();
        arst = 1'b0;
        #1;
        check("rst_first_valid", imem_req_valid_out, 1);
        check("rst_first_addr", imem_req_addr_out, pc_in);
        instr_ready_in = 1'b1;
        repeat (6) step();
        drain();

        // Random handshakes: pointer wrap over many fetches.
        d0 = n_deq;
        t  = 0;
        while (n_deq - d0 < 4 * DEPTH && t < 400) begin
            imem_req_ready_in = $urandom_range(0, 3) != 0;
            instr_ready_in    = $urandom_range(0, 3) != 0;
            mem_en            = $urandom_range(0, 3) != 0;
            drive_rsp();
            step();
            t++;
        end
        check("wrap_progress", n_deq - d0 >= 4 * DEPTH, 1);

        // Random handshakes with occasional (sometimes back-to-back) flushes.
        repeat (300) begin
            imem_req_ready_in = $urandom_range(0, 3) != 0;
            instr_ready_in    = $urandom_range(0, 3) != 0;
            mem_en            = $urandom_range(0, 3) != 0;
            drive_rsp();
            if ($urandom_range(0, 11) == 0) begin
                flush_in = 1'b1;
                pc_in    = {20'h0, 4'($urandom_range(1, 15)), 8'h00};
            end else begin
                flush_in = 1'b0;
            end
            step();
        end
        flush_in = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
